// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS.hh stopwatch control and datapath.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_LAP     = 2'b11
  } sw_state_t;

  // Terminal display value 59:59.99, BCD per digit pair
  localparam logic [7:0] MAX_MIN_BCD  = 8'h59;
  localparam logic [7:0] MAX_SEC_BCD  = 8'h59;
  localparam logic [7:0] MAX_HUND_BCD = 8'h99;

  // Clock cycles per count-enable tick
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, stable-level debouncer and rising-edge press pulse
// for one raw push-button.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] stable_cnt;

  // Bring the raw button into the clock domain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
    end
  end

  // Flip the accepted level only after an unbroken run of disagreement
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level      <= 1'b0;
      stable_cnt <= '0;
    end else if (sync_2 != level) begin
      if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level      <= sync_2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end else begin
      stable_cnt <= '0;
    end
  end

  // Delayed copy of the level for rising-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) level_d <= 1'b0;
    else       level_d <= level;
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: button conditioning, RUNNING/PAUSED/LAP state machine,
// 1/100 s tick prescaler and the clear / freeze controls for the digit datapath.
//
// state   | meaning
// IDLE    | stopped at zero, prescaler held at 0
// RUNNING | counting, display live
// PAUSED  | counting halted, prescaler fraction kept
// LAP     | counting, display frozen
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  input  logic       counter_max,
  output logic       tick,
  output logic       clear,
  output logic       freeze,
  output logic       running,
  output logic [1:0] state
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = $clog2(DIV);

  sw_state_t     state_q, state_n;
  logic [PW-1:0] presc_q, presc_n;
  logic          ss_p, lr_p;
  logic          tick_req, tick_n, clear_n;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (btn_start_stop),
    .press   (ss_p)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lr (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (btn_lap_reset),
    .press   (lr_p)
  );

  // Next state, prescaler and pulse requests; overflow outranks buttons,
  // start/stop outranks lap/reset
  always_comb begin
    state_n  = state_q;
    presc_n  = presc_q;
    tick_req = 1'b0;
    tick_n   = 1'b0;
    clear_n  = 1'b0;

    if (state_q == ST_RUNNING || state_q == ST_LAP) begin
      if (presc_q == PW'(DIV - 1)) begin
        presc_n  = '0;
        tick_req = 1'b1;
      end else begin
        presc_n = presc_q + 1'b1;
      end
    end else if (state_q == ST_IDLE) begin
      presc_n = '0;
    end

    if (tick_req && counter_max) begin
      state_n = ST_PAUSED;
    end else begin
      tick_n = tick_req;
      case (state_q)
        ST_IDLE: begin
          if (ss_p)      state_n = ST_RUNNING;
          else if (lr_p) clear_n = 1'b1;
        end
        ST_RUNNING: begin
          if (ss_p)      state_n = ST_PAUSED;
          else if (lr_p) state_n = ST_LAP;
        end
        ST_LAP: begin
          if (ss_p)      state_n = ST_PAUSED;
          else if (lr_p) state_n = ST_RUNNING;
        end
        ST_PAUSED: begin
          if (ss_p) begin
            state_n = ST_RUNNING;
          end else if (lr_p) begin
            state_n = ST_IDLE;
            clear_n = 1'b1;
            presc_n = '0;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // State, prescaler and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      tick    <= 1'b0;
      clear   <= 1'b0;
      freeze  <= 1'b0;
      running <= 1'b0;
    end else begin
      state_q <= state_n;
      presc_q <= presc_n;
      tick    <= tick_n;
      clear   <= clear_n;
      freeze  <= (state_n == ST_LAP);
      running <= (state_n == ST_RUNNING) || (state_n == ST_LAP);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10 and a 4-cycle debounce.
// Timeline indices are negedges counted from the first start/stop press.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start_stop = 1'b0;
  logic       btn_lap_reset = 1'b0;
  logic       counter_max = 1'b0;
  logic       tick, clear, freeze, running;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int nc = 0;
  int tick_seen = 0;
  int clear_seen = 0;
  int snap = 0;

  always #5 clock = ~clock;

  stopwatch_ctrl #(
    .CLK_HZ          (1000),
    .TICK_HZ         (100),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_lap_reset  (btn_lap_reset),
    .counter_max    (counter_max),
    .tick           (tick),
    .clear          (clear),
    .freeze         (freeze),
    .running        (running),
    .state          (state)
  );

  // Count tick and clear pulses just after each edge
  always @(posedge clock) begin
    #1;
    if (tick)  tick_seen++;
    if (clear) clear_seen++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      nc++;
    end
  endtask

  task automatic go_to(input int t);
    if (t > nc) step(t - nc);
  endtask

  initial begin
    step(3);
    check_val("rst_state", 32'(state), 32'(ST_IDLE));
    check_val("rst_tick", 32'(tick), 0);
    check_val("rst_clear", 32'(clear), 0);
    check_val("rst_freeze", 32'(freeze), 0);
    check_val("rst_running", 32'(running), 0);
    reset = 1'b0;
    step(2);

    // 3-cycle glitch on lap/reset must be rejected
    btn_lap_reset = 1'b1;
    step(3);
    btn_lap_reset = 1'b0;
    step(12);
    check_val("glitch_state", 32'(state), 32'(ST_IDLE));
    check_val("glitch_clear", 32'(clear_seen), 0);
    check_val("glitch_tick", 32'(tick_seen), 0);

    // Start from IDLE, 8-cycle press
    nc = 0;
    btn_start_stop = 1'b1;
    go_to(6);  check_val("start_pre", 32'(state), 32'(ST_IDLE));
    go_to(7);  check_val("start_state", 32'(state), 32'(ST_RUNNING));
               check_val("start_running", 32'(running), 1);
    go_to(8);  btn_start_stop = 1'b0;
    go_to(16); check_val("tick1_pre", 32'(tick), 0);
    go_to(17); check_val("tick1", 32'(tick), 1);
    go_to(18); check_val("tick1_width", 32'(tick), 0);
    go_to(26); check_val("tick2_pre", 32'(tick), 0);
    go_to(27); check_val("tick2", 32'(tick), 1);

    // Lap press while running
    btn_lap_reset = 1'b1;
    go_to(33); check_val("lap_pre", 32'(state), 32'(ST_RUNNING));
               check_val("lap_pre_frz", 32'(freeze), 0);
    go_to(34); check_val("lap_state", 32'(state), 32'(ST_LAP));
               check_val("lap_freeze", 32'(freeze), 1);
               check_val("lap_running", 32'(running), 1);
    go_to(35); btn_lap_reset = 1'b0;
    go_to(36); check_val("lap_tick_pre", 32'(tick), 0);
    go_to(37); check_val("lap_tick", 32'(tick), 1);
    go_to(47); check_val("lap_tick2", 32'(tick), 1);
    go_to(50); btn_lap_reset = 1'b1;
    go_to(56); check_val("unlap_pre", 32'(state), 32'(ST_LAP));
    go_to(57); check_val("unlap_state", 32'(state), 32'(ST_RUNNING));
               check_val("unlap_freeze", 32'(freeze), 0);
               check_val("unlap_tick", 32'(tick), 1);
    go_to(58); btn_lap_reset = 1'b0;

    // Pause with prescaler at 6, hold 50 cycles, resume
    go_to(66); btn_start_stop = 1'b1;
    go_to(72); check_val("pause_pre", 32'(state), 32'(ST_RUNNING));
    go_to(73); check_val("pause_state", 32'(state), 32'(ST_PAUSED));
               check_val("pause_running", 32'(running), 0);
               snap = tick_seen;
    go_to(74); btn_start_stop = 1'b0;
    go_to(123); check_val("pause_no_tick", 32'(tick_seen), 32'(snap));
    btn_start_stop = 1'b1;
    go_to(129); check_val("resume_pre", 32'(state), 32'(ST_PAUSED));
    go_to(130); check_val("resume_state", 32'(state), 32'(ST_RUNNING));
    go_to(131); btn_start_stop = 1'b0;
    go_to(133); check_val("resume_tick_pre", 32'(tick), 0);
    go_to(134); check_val("resume_tick", 32'(tick), 1);
    go_to(144); check_val("resume_tick2", 32'(tick), 1);

    // Pause, then lap/reset clears to IDLE
    btn_start_stop = 1'b1;
    go_to(151); check_val("pause2_state", 32'(state), 32'(ST_PAUSED));
    go_to(152); btn_start_stop = 1'b0;
    go_to(160); snap = clear_seen; btn_lap_reset = 1'b1;
    go_to(166); check_val("clr_pre_state", 32'(state), 32'(ST_PAUSED));
                check_val("clr_pre", 32'(clear), 0);
    go_to(167); check_val("clr_state", 32'(state), 32'(ST_IDLE));
                check_val("clr_pulse", 32'(clear), 1);
    go_to(168); check_val("clr_width", 32'(clear), 0);
                btn_lap_reset = 1'b0;

    // Lap/reset in IDLE: clear pulse, stay IDLE
    go_to(175); btn_lap_reset = 1'b1;
    go_to(182); check_val("idle_clr", 32'(clear), 1);
                check_val("idle_clr_state", 32'(state), 32'(ST_IDLE));
    go_to(183); check_val("idle_clr_width", 32'(clear), 0);
                check_val("clr_count", 32'(clear_seen), 32'(snap + 2));
                btn_lap_reset = 1'b0;

    // Restart: first tick a full period later, prescaler was zeroed
    go_to(190); btn_start_stop = 1'b1;
    go_to(196); check_val("restart_pre", 32'(state), 32'(ST_IDLE));
    go_to(197); check_val("restart_state", 32'(state), 32'(ST_RUNNING));
    go_to(198); btn_start_stop = 1'b0;
    go_to(206); check_val("restart_tick_pre", 32'(tick), 0);
    go_to(207); check_val("restart_tick", 32'(tick), 1);

    // Overflow at 59:59.99
    go_to(210); counter_max = 1'b1; snap = tick_seen;
    go_to(216); check_val("ovf_pre", 32'(state), 32'(ST_RUNNING));
    go_to(217); check_val("ovf_state", 32'(state), 32'(ST_PAUSED));
                check_val("ovf_tick", 32'(tick), 0);
                check_val("ovf_running", 32'(running), 0);
                check_val("ovf_freeze", 32'(freeze), 0);
    go_to(219); check_val("ovf_no_tick", 32'(tick_seen), 32'(snap));
                counter_max = 1'b0;

    // Both buttons together from PAUSED: start/stop wins
    go_to(220); snap = clear_seen; btn_start_stop = 1'b1; btn_lap_reset = 1'b1;
    go_to(226); check_val("both_pre", 32'(state), 32'(ST_PAUSED));
    go_to(227); check_val("both_state", 32'(state), 32'(ST_RUNNING));
                check_val("both_clear", 32'(clear), 0);
    go_to(228); check_val("both_no_clr", 32'(clear_seen), 32'(snap));
                btn_start_stop = 1'b0; btn_lap_reset = 1'b0;

    // Enter LAP, then asynchronous reset between edges
    go_to(235); btn_lap_reset = 1'b1;
    go_to(241); check_val("lap3_pre", 32'(state), 32'(ST_RUNNING));
    go_to(242); check_val("lap3_state", 32'(state), 32'(ST_LAP));
                check_val("lap3_freeze", 32'(freeze), 1);
    go_to(243); btn_lap_reset = 1'b0;
    go_to(245);
    #2 reset = 1'b1;
    #1;
    check_val("arst_state", 32'(state), 32'(ST_IDLE));
    check_val("arst_freeze", 32'(freeze), 0);
    check_val("arst_running", 32'(running), 0);
    check_val("arst_tick", 32'(tick), 0);
    check_val("arst_clear", 32'(clear), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
